ft245_sync_bus_arbiter: RTL and testbench
=========================================

# ft245_sync_bus_arbiter

Schedules the half-duplex FT245 synchronous FIFO bus between the receive direction (device to FPGA, AXIS master side) and the transmit direction (FPGA to AXIS slave side). It drives OE#, RD#, WR# and the FPGA data/byte-enable tristate enable, and inserts bus turnaround cycles between directions. Burst limits plus round-robin grant prevent either direction from starving the other. It sits between the FT245 pins and the AXIS data registers; it owns bus direction only and never touches data.

## Interface
- `burst_max`, default 512: maximum beats per grant; 0 means unlimited.
- `turn_cycles`, default 1: idle cycles with no driver before TX drive and after RX release; must be at least 1.
- `ft245_dclk` input 1: FT245 60 MHz clock; the only clock.
- `rst` input 1: synchronous, active-high reset.
- `ft245_rxfn` input 1: low means the device has RX data.
- `ft245_txen` input 1: low means the device can accept TX data.
- `ft245_oen` output 1: device output enable, active low.
- `ft245_rdn` output 1: read strobe, active low.
- `ft245_wrn` output 1: write strobe, active low.
- `data_oe` output 1: high means the FPGA drives data and byte enables.
- `rx_ready` input 1: downstream AXIS tready.
- `tx_valid` input 1: upstream AXIS tvalid.
- `rx_beat` output 1: a byte/word is transferred device to FPGA this cycle.
- `tx_beat` output 1: a word is transferred FPGA to device this cycle.
- `rx_grant` output 1: state is RX_OE or RX_XFER.
- `tx_grant` output 1: state is TX_TURN or TX_XFER.

## Operation
Definitions:
- rx_pend = ~ft245_rxfn & rx_ready.
- tx_pend = ~ft245_txen & tx_valid.
- last_dir is a register with values RX or TX. It resets to TX, so RX wins the first tie.

States, one-hot or encoded: IDLE, RX_OE, RX_XFER, RX_END, TX_TURN, TX_XFER, TX_END.

- **IDLE**
  - If rx_pend and (~tx_pend or last_dir==TX), go to RX_OE.
  - Else if tx_pend, go to TX_TURN.
  - Else stay in IDLE.
- **RX_OE**
  - Registered ft245_oen goes 0; rdn stays high.
  - Go to RX_XFER after one cycle.
  - Clear the burst counter.
- **RX_XFER**
  - ft245_rdn = ~rx_ready (combinational).
  - rx_beat = ~ft245_rxfn & rx_ready.
  - Burst counter increments on each rx_beat.
  - Exit to RX_END when ft245_rxfn is high, or when rx_beat occurs with count == burst_max-1 (burst_max != 0).
  - While rx_ready is low, stay here with rdn high.
- **RX_END**
  - ft245_oen returns to 1 and rdn is high.
  - Wait turn_cycles cycles, then go to IDLE.
  - Set last_dir = RX.
- **TX_TURN**
  - data_oe is registered to 1.
  - Wait turn_cycles cycles, then go to TX_XFER.
  - Clear the burst counter.
- **TX_XFER**
  - ft245_wrn = ~(~ft245_txen & tx_valid) (combinational).
  - tx_beat = ~ft245_wrn.
  - Exit to TX_END when ft245_txen is high, tx_valid is low, or tx_beat occurs with count == burst_max-1.
- **TX_END**
  - ft245_wrn is high and data_oe is registered to 0.
  - After one cycle, go to IDLE.
  - Set last_dir = TX.

Rules:
- Burst counter width is $clog2(burst_max+1), minimum 1. It saturates and never wraps.
- The turnaround counter width is $clog2(turn_cycles+1).
- Invariant: data_oe and ~ft245_oen are never high in the same cycle.
- Invariant: ft245_rdn and ft245_wrn are never both low.

## Timing
- Reset, synchronous: state=IDLE, ft245_oen=1, ft245_rdn=1, ft245_wrn=1, data_oe=0, rx_beat=0, tx_beat=0, rx_grant=0, tx_grant=0, counters=0, last_dir=TX.
  - Asserting rst mid-burst forces these values on the next edge.
  - Combinational strobes are gated by state, so they deassert at that same edge.
- RX latency: with rx_pend in IDLE at cycle 0, the FSM is in RX_OE at cycle 1 (oen low) and RX_XFER at cycle 2 (rdn low). The first rx_beat can occur in cycle 2.
- RX sustained rate: one beat per cycle while ~ft245_rxfn & rx_ready.
- TX latency: with tx_pend in IDLE at cycle 0, data_oe goes high at cycle 1. The first WR# low occurs at cycle 1+turn_cycles.
- Direction switch cost:
  - RX to TX minimum gap: turn_cycles+1+turn_cycles cycles between the last rx_beat and the first tx_beat.
  - TX to RX minimum gap: 1+1+1 cycles.
- Simultaneous rx_pend and tx_pend in IDLE: the grant goes to the direction not in last_dir.
- If a condition deasserts while in RX_OE or TX_TURN, the sequence still completes. It reaches XFER and exits on the next cycle with zero beats.

## Test plan
- **RX burst.** Hold rxfn low and rx_ready high for 10 cycles, with burst_max=512.
  - oen falls 1 cycle after request; rdn falls 1 cycle later.
  - Ten rx_beats, then oen high, then IDLE after turn_cycles.
- **Burst limit and round-robin.** burst_max=4, rxfn and txen held low, tx_valid and rx_ready high.
  - Beat pattern is 4 RX, turnaround, 4 TX, repeating.
  - data_oe is never high while oen is low.
- **RX backpressure.** During RX_XFER, drop rx_ready for 3 cycles.
  - rdn is high and there is no rx_beat for those 3 cycles.
  - The grant is held and resumes without re-entering RX_OE.
- **TX device full.** txen goes high after 2 tx_beats.
  - wrn rises the same cycle.
  - TX_END follows, data_oe falls one cycle later, then IDLE.
- **Reset mid-transfer.** Assert rst during TX_XFER.
  - Next cycle: wrn=1, data_oe=0, oen=1, all grants 0, state IDLE.
  - After release, the first tie goes to RX.

Source files
------------

// File: rtl/ft245_sync_bus_arbiter.sv
// Purpose: decides which direction owns the half-duplex FT245 sync FIFO bus and drives OE#/RD#/WR#/data_oe.
// Latency: an RX request gets OE# low 1 cycle later and RD# 2 cycles later; a TX request gets data_oe 1 cycle later and WR# 1+turn_cycles cycles later.
// Backpressure: a low rx_ready holds RD# high while keeping the grant; WR# follows txen/tx_valid combinationally.
module ft245_sync_bus_arbiter #(
    parameter int burst_max   = 512,
    parameter int turn_cycles = 1
) (
    input  logic ft245_dclk,
    input  logic rst,
    input  logic ft245_rxfn,
    input  logic ft245_txen,
    output logic ft245_oen,
    output logic ft245_rdn,
    output logic ft245_wrn,
    output logic data_oe,
    input  logic rx_ready,
    input  logic tx_valid,
    output logic rx_beat,
    output logic tx_beat,
    output logic rx_grant,
    output logic tx_grant
);

    localparam int BW = (burst_max > 0) ? $clog2(burst_max + 1) : 1;
    localparam int TW = (turn_cycles > 1) ? $clog2(turn_cycles + 1) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'((burst_max > 0) ? (burst_max - 1) : 0);
    localparam logic [TW-1:0] TURN_LAST  = TW'((turn_cycles > 0) ? (turn_cycles - 1) : 0);

    typedef enum logic [2:0] {
        IDLE,
        RX_OE,
        RX_XFER,
        RX_END,
        TX_TURN,
        TX_XFER,
        TX_END
    } state_t;

    state_t          state;
    logic            last_dir_tx;
    logic [BW-1:0]   burst_cnt;
    logic [TW-1:0]   turn_cnt;
    logic            rx_pend;
    logic            tx_pend;
    logic            burst_last;

    assign rx_pend    = ~ft245_rxfn & rx_ready;
    assign tx_pend    = ~ft245_txen & tx_valid;
    // A limit of zero means the burst only ends when the device or source stops.
    assign burst_last = (burst_max != 0) && (burst_cnt == BURST_LAST);

    // Strobes and beats are gated by state so that a reset drops them at the same edge.
    always_comb begin
        rx_beat   = (state == RX_XFER) & rx_pend;
        tx_beat   = (state == TX_XFER) & tx_pend;
        ft245_rdn = ~((state == RX_XFER) & rx_ready);
        ft245_wrn = ~tx_beat;
        rx_grant  = (state == RX_OE) | (state == RX_XFER);
        tx_grant  = (state == TX_TURN) | (state == TX_XFER);
    end

    // Bus scheduling FSM with registered OE# and data_oe, burst and turnaround counters.
    always_ff @(posedge ft245_dclk) begin
        if (rst) begin
            state       <= IDLE;
            ft245_oen   <= 1'b1;
            data_oe     <= 1'b0;
            last_dir_tx <= 1'b1;
            burst_cnt   <= '0;
            turn_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Ties go to whichever direction did not own the bus last.
                    if (rx_pend && (!tx_pend || last_dir_tx)) begin
                        state     <= RX_OE;
                        ft245_oen <= 1'b0;
                    end else if (tx_pend) begin
                        state   <= TX_TURN;
                        data_oe <= 1'b1;
                    end
                end
                RX_OE: begin
                    burst_cnt <= '0;
                    state     <= RX_XFER;
                end
                RX_XFER: begin
                    if (rx_beat && (burst_cnt != {BW{1'b1}})) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                    if (ft245_rxfn || (rx_beat && burst_last)) begin
                        state     <= RX_END;
                        ft245_oen <= 1'b1;
                    end
                end
                RX_END: begin
                    // Device releases the bus here; hold off any new driver for the turnaround.
                    last_dir_tx <= 1'b0;
                    if (turn_cnt == TURN_LAST) begin
                        turn_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                TX_TURN: begin
                    burst_cnt <= '0;
                    if (turn_cnt == TURN_LAST) begin
                        turn_cnt <= '0;
                        state    <= TX_XFER;
                    end else begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                TX_XFER: begin
                    if (tx_beat && (burst_cnt != {BW{1'b1}})) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                    if (ft245_txen || !tx_valid || (tx_beat && burst_last)) begin
                        state <= TX_END;
                    end
                end
                TX_END: begin
                    last_dir_tx <= 1'b1;
                    data_oe     <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ft245_sync_bus_arbiter.sv
// Purpose: checks bus scheduling of two arbiter instances (long bursts / short bursts with 2-cycle turnaround).
// Latency: expected beat cycles are queued as stimulus is driven and matched when beats appear.
// Backpressure: rx_ready and txen are toggled by the scenarios to exercise stalls and early exits.
module tb_ft245_sync_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic a_rxfn, a_txen, a_rx_ready, a_tx_valid;
    logic a_oen, a_rdn, a_wrn, a_doe, a_rxb, a_txb, a_rxg, a_txg;
    logic b_rxfn, b_txen, b_rx_ready, b_tx_valid;
    logic b_oen, b_rdn, b_wrn, b_doe, b_rxb, b_txb, b_rxg, b_txg;

    ft245_sync_bus_arbiter #(.burst_max(512), .turn_cycles(1)) u_dut_a (
        .ft245_dclk (clk),
        .rst        (rst),
        .ft245_rxfn (a_rxfn),
        .ft245_txen (a_txen),
        .ft245_oen  (a_oen),
        .ft245_rdn  (a_rdn),
        .ft245_wrn  (a_wrn),
        .data_oe    (a_doe),
        .rx_ready   (a_rx_ready),
        .tx_valid   (a_tx_valid),
        .rx_beat    (a_rxb),
        .tx_beat    (a_txb),
        .rx_grant   (a_rxg),
        .tx_grant   (a_txg)
    );

    ft245_sync_bus_arbiter #(.burst_max(4), .turn_cycles(2)) u_dut_b (
        .ft245_dclk (clk),
        .rst        (rst),
        .ft245_rxfn (b_rxfn),
        .ft245_txen (b_txen),
        .ft245_oen  (b_oen),
        .ft245_rdn  (b_rdn),
        .ft245_wrn  (b_wrn),
        .data_oe    (b_doe),
        .rx_ready   (b_rx_ready),
        .tx_valid   (b_tx_valid),
        .rx_beat    (b_rxb),
        .tx_beat    (b_txb),
        .rx_grant   (b_rxg),
        .tx_grant   (b_txg)
    );

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int qa[$];
    int qb[$];
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drv(input logic rxfn, input logic txen, input logic rr, input logic tv);
        a_rxfn = rxfn; a_txen = txen; a_rx_ready = rr; a_tx_valid = tv;
    endtask

    task automatic b_drv(input logic rxfn, input logic txen, input logic rr, input logic tv);
        b_rxfn = rxfn; b_txen = txen; b_rx_ready = rr; b_tx_valid = tv;
    endtask

    // Beat scoreboard (event = cycle*2 + dir, dir 0=RX 1=TX) and bus invariants.
    always @(negedge clk) begin
        if (mon_en) begin
            if (a_rxb === 1'b1) begin
                if (qa.size() == 0) chk("a_unexpected_rx", cyc * 2, 32'hFFFF_FFFF);
                else                chk("a_rx_beat", cyc * 2, qa.pop_front());
            end
            if (a_txb === 1'b1) begin
                if (qa.size() == 0) chk("a_unexpected_tx", cyc * 2 + 1, 32'hFFFF_FFFF);
                else                chk("a_tx_beat", cyc * 2 + 1, qa.pop_front());
            end
            if (b_rxb === 1'b1) begin
                if (qb.size() == 0) chk("b_unexpected_rx", cyc * 2, 32'hFFFF_FFFF);
                else                chk("b_rx_beat", cyc * 2, qb.pop_front());
            end
            if (b_txb === 1'b1) begin
                if (qb.size() == 0) chk("b_unexpected_tx", cyc * 2 + 1, 32'hFFFF_FFFF);
                else                chk("b_tx_beat", cyc * 2 + 1, qb.pop_front());
            end
            chk("a_oe_clash", {31'd0, a_doe & ~a_oen}, 32'd0);
            chk("b_oe_clash", {31'd0, b_doe & ~b_oen}, 32'd0);
            chk("a_strobe_clash", {31'd0, ~a_rdn & ~a_wrn}, 32'd0);
            chk("b_strobe_clash", {31'd0, ~b_rdn & ~b_wrn}, 32'd0);
        end
    end

    initial begin
        rst = 1'b1;
        a_drv(1, 1, 0, 0);
        b_drv(1, 1, 0, 0);
        repeat (3) tick();
        @(negedge clk);
        chk("rst_a_oen", a_oen, 1); chk("rst_a_rdn", a_rdn, 1); chk("rst_a_wrn", a_wrn, 1);
        chk("rst_a_doe", a_doe, 0); chk("rst_a_rxg", a_rxg, 0); chk("rst_a_txg", a_txg, 0);
        chk("rst_a_rxb", a_rxb, 0); chk("rst_a_txb", a_txb, 0);
        chk("rst_b_oen", b_oen, 1); chk("rst_b_doe", b_doe, 0);
        mon_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // RX burst of ten beats, ended by the device going empty.
        for (int i = 0; i <= 14; i++) begin
            a_drv(i > 11, 1, 1, 0);
            if (i >= 2 && i <= 11) qa.push_back(cyc * 2);
            @(negedge clk);
            case (i)
                0:  chk("rx_idle_oen", a_oen, 1);
                1:  begin chk("rx_oe_oen", a_oen, 0); chk("rx_oe_rdn", a_rdn, 1); chk("rx_oe_grant", a_rxg, 1); end
                2:  chk("rx_xfer_rdn", a_rdn, 0);
                12: chk("rx_empty_oen", a_oen, 0);
                13: begin chk("rx_end_oen", a_oen, 1); chk("rx_end_grant", a_rxg, 0); chk("rx_end_rdn", a_rdn, 1); end
                14: begin chk("rx_idle2_rxg", a_rxg, 0); chk("rx_idle2_txg", a_txg, 0); end
                default: ;
            endcase
            tick();
        end
        a_drv(1, 1, 0, 0);
        tick();
        chk("rx_burst_left", qa.size(), 0);

        // TX with device going full after two beats.
        for (int i = 0; i <= 7; i++) begin
            a_drv(1, i >= 4, 0, 1);
            if (i == 2 || i == 3) qa.push_back(cyc * 2 + 1);
            @(negedge clk);
            case (i)
                0: chk("tx_idle_doe", a_doe, 0);
                1: begin chk("tx_turn_doe", a_doe, 1); chk("tx_turn_wrn", a_wrn, 1); chk("tx_turn_grant", a_txg, 1); end
                2: chk("tx_first_wrn", a_wrn, 0);
                4: begin chk("tx_full_wrn", a_wrn, 1); chk("tx_full_grant", a_txg, 1); end
                5: begin chk("tx_end_grant", a_txg, 0); chk("tx_end_doe", a_doe, 1); end
                6: chk("tx_idle_doe_low", a_doe, 0);
                default: ;
            endcase
            tick();
        end
        a_drv(1, 1, 0, 0);
        tick();
        chk("tx_full_left", qa.size(), 0);

        // RX backpressure: rx_ready low for three cycles mid-burst.
        for (int i = 0; i <= 11; i++) begin
            a_drv(i >= 9, 1, !(i >= 4 && i <= 6), 0);
            if (i == 2 || i == 3 || i == 7 || i == 8) qa.push_back(cyc * 2);
            @(negedge clk);
            if (i >= 4 && i <= 6) begin
                chk("bp_rdn", a_rdn, 1); chk("bp_grant", a_rxg, 1); chk("bp_oen", a_oen, 0);
            end
            if (i == 7) chk("bp_resume_rdn", a_rdn, 0);
            if (i == 10) chk("bp_end_oen", a_oen, 1);
            tick();
        end
        a_drv(1, 1, 0, 0);
        tick();
        chk("bp_left", qa.size(), 0);

        // Reset during TX_XFER, then a tie that must go to RX.
        for (int i = 0; i <= 12; i++) begin
            a_drv(!(i >= 6 && i < 10), i >= 10, 1, i < 10);
            rst = (i == 4 || i == 5);
            if (i >= 2 && i <= 4) qa.push_back(cyc * 2 + 1);
            if (i == 8 || i == 9) qa.push_back(cyc * 2);
            @(negedge clk);
            case (i)
                4: chk("mid_txg", a_txg, 1);
                5: begin
                    chk("mrst_wrn", a_wrn, 1); chk("mrst_doe", a_doe, 0); chk("mrst_oen", a_oen, 1);
                    chk("mrst_rxg", a_rxg, 0); chk("mrst_txg", a_txg, 0); chk("mrst_txb", a_txb, 0);
                end
                6: begin chk("post_idle_rxg", a_rxg, 0); chk("post_idle_txg", a_txg, 0); end
                7: begin chk("tie_rxg", a_rxg, 1); chk("tie_txg", a_txg, 0); chk("tie_oen", a_oen, 0); end
                default: ;
            endcase
            tick();
        end
        rst = 1'b0;
        a_drv(1, 1, 0, 0);
        tick();
        chk("mrst_left", qa.size(), 0);

        // Burst limit 4, turnaround 2, both directions always pending: 16-cycle round-robin.
        for (int i = 0; i <= 33; i++) begin
            b_drv(i >= 32, i >= 32, i < 32, i < 32);
            if (i < 32) begin
                if ((i % 16) >= 2 && (i % 16) <= 5)  qb.push_back(cyc * 2);
                if ((i % 16) >= 11 && (i % 16) <= 14) qb.push_back(cyc * 2 + 1);
            end
            @(negedge clk);
            case (i)
                1:  begin chk("rr_oe_oen", b_oen, 0); chk("rr_oe_doe", b_doe, 0); end
                6:  begin chk("rr_end_oen", b_oen, 1); chk("rr_end_doe", b_doe, 0); end
                9:  begin chk("rr_turn1_doe", b_doe, 1); chk("rr_turn1_wrn", b_wrn, 1); end
                10: begin chk("rr_turn2_txg", b_txg, 1); chk("rr_turn2_wrn", b_wrn, 1); chk("rr_turn2_oen", b_oen, 1); end
                11: chk("rr_first_wrn", b_wrn, 0);
                17: chk("rr_back_rxg", b_rxg, 1);
                default: ;
            endcase
            tick();
        end
        tick();
        chk("rr_left", qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
